// File: rtl/pixel_stream_reader_if.sv
// Bundle of the block-FIFO read port, test-pattern controls and pixel output
// port of pixel_stream_reader; master is the reader, slave is its environment.
interface pixel_stream_reader_if #(
  parameter int CHANNELS      = 3,
  parameter int CHANNEL_WIDTH = 8,
  parameter int SIZE_WIDTH    = 24
);
  localparam int PW = CHANNELS * CHANNEL_WIDTH;

  logic                  i_read_rdy;
  logic                  o_read_act;
  logic [SIZE_WIDTH-1:0] i_read_size;
  logic [PW:0]           i_read_data;
  logic                  o_read_stb;
  logic [1:0]            i_tp_mode;
  logic [CHANNELS-1:0]   i_tp_mask;
  logic [PW-1:0]         o_pixel;
  logic                  o_pixel_last;
  logic                  o_pixel_rdy;
  logic                  i_pixel_stb;
  logic [SIZE_WIDTH-1:0] o_count;

  modport master (
    input  i_read_rdy, i_read_size, i_read_data, i_tp_mode, i_tp_mask, i_pixel_stb,
    output o_read_act, o_read_stb, o_pixel, o_pixel_last, o_pixel_rdy, o_count
  );

  modport slave (
    output i_read_rdy, i_read_size, i_read_data, i_tp_mode, i_tp_mask, i_pixel_stb,
    input  o_read_act, o_read_stb, o_pixel, o_pixel_last, o_pixel_rdy, o_count
  );
endinterface

// File: rtl/pixel_stream_reader.sv
// Drains pixel blocks from a first-word-fall-through FIFO, or generates solid/ramp
// test patterns, onto a registered one-pixel-per-cycle ready/strobe output.
//
// state | meaning
// IDLE  | no block owned; waiting for a test mode or a FIFO block
// FIFO  | owning a FIFO block; popping words until r_size are loaded
// TP    | generating r_size test-pattern pixels, FIFO untouched
module pixel_stream_reader #(
  parameter int CHANNELS      = 3,
  parameter int CHANNEL_WIDTH = 8,
  parameter int SIZE_WIDTH    = 24
) (
  input logic                   clk,
  input logic                   rst_n,
  pixel_stream_reader_if.master bus
);
  localparam int PW = CHANNELS * CHANNEL_WIDTH;

  typedef enum logic [1:0] {IDLE, FIFO, TP} state_t;

  state_t                   state;
  logic [SIZE_WIDTH-1:0]    r_size;
  logic [1:0]               r_mode;
  logic                     load;
  logic [CHANNEL_WIDTH-1:0] ramp;
  logic [PW-1:0]            tp_pixel;
  logic [PW-1:0]            src_pixel;
  logic                     src_last;

  assign load = (state != IDLE) && (bus.o_count < r_size) &&
                (!bus.o_pixel_rdy || bus.i_pixel_stb);
  assign bus.o_read_stb = load && (state == FIFO);
  assign ramp = CHANNEL_WIDTH'(bus.o_count);

  // Mask is applied live so it can be changed while a pattern is running.
  always_comb begin
    tp_pixel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.i_tp_mask[c])
        tp_pixel[c*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
          (r_mode == 2'd2) ? ramp : {CHANNEL_WIDTH{1'b1}};
    end
    if (state == FIFO) begin
      src_pixel = bus.i_read_data[PW-1:0];
      src_last  = bus.i_read_data[PW];
    end else begin
      src_pixel = tp_pixel;
      src_last  = (bus.o_count == r_size - SIZE_WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      r_size           <= '0;
      r_mode           <= '0;
      bus.o_read_act   <= 1'b0;
      bus.o_pixel      <= '0;
      bus.o_pixel_last <= 1'b0;
      bus.o_pixel_rdy  <= 1'b0;
      bus.o_count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_tp_mode != 2'd0) begin
            r_size      <= bus.i_read_size;
            r_mode      <= bus.i_tp_mode;
            bus.o_count <= '0;
            state       <= TP;
          end else if (bus.i_read_rdy) begin
            r_size         <= bus.i_read_size;
            bus.o_count    <= '0;
            bus.o_read_act <= 1'b1;
            state          <= FIFO;
          end
        end
        FIFO, TP: begin
          if (bus.o_count == r_size) begin
            bus.o_read_act <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Output handshake finishes on its own even after the block is released.
      if (load) begin
        bus.o_pixel      <= src_pixel;
        bus.o_pixel_last <= src_last;
        bus.o_pixel_rdy  <= 1'b1;
        bus.o_count      <= bus.o_count + SIZE_WIDTH'(1);
      end else if (bus.o_pixel_rdy && bus.i_pixel_stb) begin
        bus.o_pixel_rdy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_reader.sv
// Directed and randomized blocks for pixel_stream_reader, checked against a
// queue-based model of the expected pixel stream and handshake timing.
module tb_pixel_stream_reader;
  localparam int CHANNELS = 3;
  localparam int CW       = 8;
  localparam int SW       = 24;
  localparam int PW       = CHANNELS * CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_stream_reader_if #(.CHANNELS(CHANNELS), .CHANNEL_WIDTH(CW), .SIZE_WIDTH(SW)) bus ();

  pixel_stream_reader #(.CHANNELS(CHANNELS), .CHANNEL_WIDTH(CW), .SIZE_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [PW:0] fifo_q[$];
  logic [PW:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW:0] tp_word(input logic [1:0] mode, input logic [CHANNELS-1:0] mask,
                                          input int k, input int size);
    logic [PW:0] w;
    w = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (mask[c]) w[c*CW +: CW] = (mode == 2'd2) ? CW'(k % (1 << CW)) : {CW{1'b1}};
    w[PW] = (k == size - 1);
    return w;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 64'({bus.o_read_act, bus.o_read_stb, bus.o_pixel_last, bus.o_pixel_rdy}), 64'(0));
    check({tag, "_pixel"}, 64'(bus.o_pixel), 64'(0));
    check({tag, "_count"}, 64'(bus.o_count), 64'(0));
  endtask

  // stb_mode: 0 = always accept, 1 = accept every third cycle, 2 = random.
  // rst_after > 0 asserts reset once that many words have been popped.
  task automatic run_block(input bit is_tp, input logic [1:0] mode, input logic [CHANNELS-1:0] mask,
                           input int size, input int stb_mode, input int rst_after);
    int cyc = 0, head = 0, pops = 0, settle = 0;
    int first_pop = -1, last_pop = -1, first_rdy = -1, first_xfer = -1, last_xfer = -1;
    int act_cycles = 0, last_act = -1;
    int budget = 4 * size + 60;
    bit acq_seen = 0, stalled = 0, was_reset = 0;
    logic [PW:0] held = '0;
    logic stb;

    exp_q = {};
    if (is_tp) for (int k = 0; k < size; k++) exp_q.push_back(tp_word(mode, mask, k, size));
    else foreach (fifo_q[i]) exp_q.push_back(fifo_q[i]);

    while (1) begin
      @(negedge clk);
      if (rst_after > 0 && pops == rst_after) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_block");
        was_reset = 1;
        break;
      end
      if (cyc == 0) begin
        bus.i_read_size = SW'(size);
        bus.i_read_rdy  = 1'b1;
        bus.i_tp_mode   = is_tp ? mode : 2'd0;
        bus.i_tp_mask   = mask;
      end else if (cyc == 1) begin
        bus.i_read_rdy  = 1'b0;
        bus.i_tp_mode   = 2'd0;
        bus.i_read_size = SW'($urandom);
      end
      case (stb_mode)
        0:       stb = 1'b1;
        1:       stb = (cyc % 3 == 0);
        default: stb = 1'($urandom_range(0, 1));
      endcase
      bus.i_pixel_stb = stb;
      bus.i_read_data = (head < fifo_q.size()) ? fifo_q[head] : '0;
      #1;

      if (is_tp) check("tp_no_fifo_access", 64'({bus.o_read_act, bus.o_read_stb}), 64'(0));
      if (bus.o_read_act) begin
        if (!acq_seen) check("count_at_acquire", 64'(bus.o_count), 64'(0));
        acq_seen = 1;
        act_cycles++;
        last_act = cyc;
      end
      if (stalled) begin
        check("stall_rdy_held", 64'(bus.o_pixel_rdy), 64'(1));
        check("stall_pixel_held", 64'({bus.o_pixel_last, bus.o_pixel}), 64'(held));
      end
      if (bus.o_pixel_rdy && !stb) check("backpressure_no_pop", 64'(bus.o_read_stb), 64'(0));
      if (bus.o_pixel_rdy && first_rdy < 0) first_rdy = cyc;
      if (bus.o_pixel_rdy && stb) begin
        check("pixel_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) check("pixel_value", 64'({bus.o_pixel_last, bus.o_pixel}), 64'(exp_q.pop_front()));
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      if (bus.o_read_stb) begin
        check("pop_in_block", 64'(head < fifo_q.size()), 64'(1));
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
        head++;
      end
      stalled = bus.o_pixel_rdy && !stb;
      held    = {bus.o_pixel_last, bus.o_pixel};
      cyc++;
      if (cyc >= 4 && exp_q.size() == 0 && !bus.o_read_act && !bus.o_pixel_rdy) settle++;
      if (settle == 3) break;
      if (cyc > budget) begin
        check("block_timeout_cycles", 64'(cyc), 64'(budget));
        break;
      end
    end

    if (!was_reset) begin
      check("pop_total", 64'(pops), 64'(is_tp ? 0 : size));
      check("final_count", 64'(bus.o_count), 64'(size));
      if (size > 0) check("first_rdy_latency", 64'(first_rdy), 64'(2));
      else          check("no_pixel_for_empty", 64'(first_rdy), 64'(-1));
      if (!is_tp) begin
        if (stb_mode == 0) check("act_cycles", 64'(act_cycles), 64'(size + 1));
        if (size > 0) begin
          check("first_pop_latency", 64'(first_pop), 64'(1));
          check("release_after_last_pop", 64'(last_act), 64'(last_pop + 1));
        end
      end
      if (stb_mode == 0 && size > 0)
        check("no_bubbles", 64'(last_xfer - first_xfer + 1), 64'(size));
    end
  endtask

  initial begin
    int size;
    bit is_tp;
    logic [1:0] mode;
    bus.i_read_rdy   = 1'b0;
    bus.i_read_size  = '0;
    bus.i_read_data  = '0;
    bus.i_tp_mode    = 2'd0;
    bus.i_tp_mask    = '0;
    bus.i_pixel_stb  = 1'b0;

    @(negedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    fifo_q = {};
    for (int i = 1; i <= 4; i++) fifo_q.push_back({(i == 4), 8'(i), 8'(i + 1), 8'(i + 2)});
    run_block(0, 2'd0, 3'b000, 4, 0, 0);
    run_block(0, 2'd0, 3'b000, 4, 1, 0);

    fifo_q = {};
    run_block(1, 2'd1, 3'b101, 3, 0, 0);
    run_block(1, 2'd2, 3'b111, 300, 0, 0);
    run_block(0, 2'd0, 3'b000, 0, 0, 0);
    run_block(1, 2'd3, 3'b010, 2, 2, 0);

    fifo_q = {};
    for (int i = 0; i < 5; i++) fifo_q.push_back((PW + 1)'($urandom));
    run_block(0, 2'd0, 3'b000, 5, 0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.i_pixel_stb = 1'b0;
    @(negedge clk);
    fifo_q = {};
    for (int i = 0; i < 3; i++) fifo_q.push_back((PW + 1)'($urandom));
    run_block(0, 2'd0, 3'b000, 3, 0, 0);

    for (int b = 0; b < 12; b++) begin
      size  = $urandom_range(0, 12);
      is_tp = 1'($urandom_range(0, 2) == 0);
      mode  = 2'($urandom_range(1, 3));
      fifo_q = {};
      if (!is_tp) for (int i = 0; i < size; i++) fifo_q.push_back((PW + 1)'($urandom));
      run_block(is_tp, mode, 3'($urandom), size, $urandom_range(0, 2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_stream_reader.md
# pixel_stream_reader

Parametrised pixel source that drains pixel blocks from a first-word-fall-through block FIFO and presents them one pixel per cycle on a registered ready/strobe output port. It generalises the single-format pixel reader to N channels of arbitrary width and adds a built-in test-pattern generator with solid and ramp modes, latched block sizing, and a sustained one-pixel-per-cycle throughput. It sits between the video frame FIFO and the display timing/serializer logic of the TFT controller.

## Interface
- CHANNELS, 3, number of colour channels per pixel
- CHANNEL_WIDTH, 8, bits per channel
- SIZE_WIDTH, 24, width of block-size and pixel-count fields
- PW (localparam) = CHANNELS*CHANNEL_WIDTH; channel c occupies bits [c*CHANNEL_WIDTH +: CHANNEL_WIDTH]
- clk  in  1  sole clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_read_rdy  in  1  a FIFO block is available
- o_read_act  out  1  block owned by this reader
- i_read_size  in  SIZE_WIDTH  words in the offered block
- i_read_data  in  PW+1  head word; bit PW = last flag, [PW-1:0] = pixel
- o_read_stb  out  1  pop head word (combinational, see Operation)
- i_tp_mode  in  2  0 = FIFO, 1 = solid, 2 = ramp, 3 = solid
- i_tp_mask  in  CHANNELS  channel enables for test patterns
- o_pixel  out  PW  output pixel
- o_pixel_last  out  1  last flag for o_pixel
- o_pixel_rdy  out  1  o_pixel valid
- i_pixel_stb  in  1  consumer accepts o_pixel (meaningful only while o_pixel_rdy)
- o_count  out  SIZE_WIDTH  pixels loaded in current/most recent block

## Operation
- States: IDLE, FIFO, TP.
- IDLE: o_read_act = 0. If i_tp_mode != 0: latch r_size <= i_read_size, r_mode <= i_tp_mode, o_count <= 0, go TP. Else if i_read_rdy: latch r_size, o_count <= 0, o_read_act <= 1, go FIFO. Test mode has priority over i_read_rdy.
- Load condition L = (state is FIFO or TP) && (o_count < r_size) && (!o_pixel_rdy || i_pixel_stb).
- o_read_stb = L && state == FIFO, combinational; FIFO pops at the same edge the word is captured.
- On L: o_pixel <= source pixel, o_pixel_last <= source last, o_pixel_rdy <= 1, o_count <= o_count + 1.
- Else if o_pixel_rdy && i_pixel_stb: o_pixel_rdy <= 0.
- FIFO source: pixel = i_read_data[PW-1:0], last = i_read_data[PW].
- TP source: solid: channel c = all ones if i_tp_mask[c] else 0. Ramp: channel c = o_count[CHANNEL_WIDTH-1:0] (zero-extended if SIZE_WIDTH < CHANNEL_WIDTH) if mask[c] else 0. last = (o_count == r_size - 1).
- Block end: in FIFO or TP with o_count == r_size: go IDLE; in FIFO, o_read_act <= 0. The output register may still hold the final pixel; its handshake completes independently of state.
- r_size == 0: enter state, no loads, release on next edge. o_read_act is high exactly one cycle; no pixels are produced.
- i_tp_mode, i_tp_mask, and i_read_size changes mid-block: mode and size are ignored until IDLE. The mask is sampled live on every load.
- o_read_stb is never asserted outside FIFO state, nor when o_count == r_size.

## Timing
- Reset (rst_n low, asynchronous): state IDLE. o_read_act = 0, o_read_stb = 0, o_pixel = 0, o_pixel_last = 0, o_pixel_rdy = 0, o_count = 0, r_size = 0. Holds through mid-block; no pop leaks.
- Acquire: i_read_rdy sampled at edge E0 sets o_read_act. o_read_stb is high in the cycle after E0 (output empty). o_pixel_rdy is high after E1. Latency is 2 edges.
- Throughput: 1 pixel/cycle with i_pixel_stb held high; no bubbles within a block.
- Release: o_read_act falls at the edge after the edge of the last pop. It stays low at least one cycle before re-acquire.
- Back-pressure: with o_pixel_rdy high and i_pixel_stb low, o_pixel, o_pixel_last, and o_count hold, and o_read_stb = 0.

## Test plan
- FIFO block, size 4, data 0x010203..0x040506 with bit 24 set on the 4th, stb held high -> o_read_act high 5 cycles, o_read_stb 4 consecutive pulses, o_pixel sequence matches, o_pixel_last on 4th only, o_count = 4.
- Same block, i_pixel_stb toggled 1,0,0,1,… -> no pixel lost or duplicated; o_read_stb only in cycles where the output register frees; o_pixel stable while stalled.
- i_tp_mode = 1, mask = 3'b101, size 3 -> three pixels 0xFF00FF, last on the 3rd, o_read_stb never asserted, o_read_act stays 0.
- i_tp_mode = 2, mask = 3'b111, size 300, CHANNEL_WIDTH = 8 -> channels ramp 0..255 then wrap to 0..43. Last on pixel 300.
- Size 0 FIFO block -> o_read_act high one cycle, no o_read_stb, o_pixel_rdy stays 0.
- rst_n asserted mid-block after 2 of 5 pops -> all outputs 0 immediately. After release and i_read_rdy, a new block starts with o_count = 0.
